// File: rtl/fifo_to_sram_mc.sv
// Multi-channel drain engine: round-robin selection of threshold-ready sample FIFOs,
// burst transfer of samples into the SRAM writer with a per-channel wrapping word address.
module fifo_to_sram_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5,
  parameter int NUM_CH     = 4,
  parameter int CH_BITS    = 2,
  parameter int OFS_WIDTH  = 8
) (
  input  logic                            wb_clk,
  input  logic                            wb_rst_n,
  input  logic                            enable,
  input  logic [CNT_WIDTH-1:0]            terminal,
  input  logic [CNT_WIDTH-1:0]            burst_len,
  input  logic [NUM_CH-1:0]               empty,
  input  logic [NUM_CH*CNT_WIDTH-1:0]     number_samples,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    fifo_data_in,
  input  logic                            grant,
  input  logic                            data_done,
  output logic [NUM_CH-1:0]               pop,
  output logic                            sram_start,
  output logic [DATA_WIDTH-1:0]           sram_data_out,
  output logic [CH_BITS+OFS_WIDTH-1:0]    sram_addr,
  output logic                            busy
);

  // state  | meaning
  // IDLE   | waiting for enable and an eligible channel
  // POP    | one-cycle pop of the selected FIFO
  // LOAD   | capture FIFO data and build {channel, offset}
  // REQ    | sram_start held until grant
  // XFER   | waiting for data_done, then next sample or back to IDLE
  typedef enum logic [2:0] {S_IDLE, S_POP, S_LOAD, S_REQ, S_XFER} state_t;

  state_t                 state, state_nxt;
  logic [CH_BITS-1:0]     ch, rr_ptr, sel_ch, idx;
  logic                   sel_found;
  logic [CNT_WIDTH-1:0]   cnt, burst_eff;
  logic [OFS_WIDTH-1:0]   offset [NUM_CH];
  logic [NUM_CH-1:0]      elig;
  logic                   ld_sel, ld_data, done_word, end_burst;

  assign burst_eff = (burst_len == '0) ? CNT_WIDTH'(1) : burst_len;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++)
      elig[i] = !empty[i] && (number_samples[i*CNT_WIDTH +: CNT_WIDTH] >= terminal);
  end

  // Descending scan so the channel closest to the pointer wins.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    idx       = '0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      idx = CH_BITS'((int'(rr_ptr) + k) % NUM_CH);
      if (elig[idx]) begin
        sel_found = 1'b1;
        sel_ch    = idx;
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = '0;
    sram_start = 1'b0;
    busy       = (state != S_IDLE);
    ld_sel     = 1'b0;
    ld_data    = 1'b0;
    done_word  = 1'b0;
    end_burst  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && sel_found) begin
          ld_sel    = 1'b1;
          state_nxt = S_POP;
        end
      end
      S_POP: begin
        pop[ch]   = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld_data   = 1'b1;
        state_nxt = S_REQ;
      end
      S_REQ: begin
        sram_start = 1'b1;
        if (grant) state_nxt = S_XFER;
      end
      S_XFER: begin
        if (data_done) begin
          done_word = 1'b1;
          if (cnt != CNT_WIDTH'(1) && !empty[ch]) begin
            state_nxt = S_POP;
          end else begin
            end_burst = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ch            <= '0;
      rr_ptr        <= '0;
      cnt           <= '0;
      sram_data_out <= '0;
      sram_addr     <= '0;
      for (int i = 0; i < NUM_CH; i++) offset[i] <= '0;
    end else begin
      if (ld_sel) begin
        ch  <= sel_ch;
        cnt <= burst_eff;
      end
      if (ld_data) begin
        sram_data_out <= fifo_data_in[ch*DATA_WIDTH +: DATA_WIDTH];
        sram_addr     <= {ch, offset[ch]};
      end
      if (done_word) begin
        offset[ch] <= offset[ch] + 1'b1;
        cnt        <= cnt - 1'b1;
      end
      if (end_burst)
        rr_ptr <= (ch == CH_BITS'(NUM_CH-1)) ? '0 : ch + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_to_sram_mc.sv
// Bench for fifo_to_sram_mc: FIFO and SRAM-writer models, scoreboard of expected writes,
// two instances (8-bit and 2-bit offsets) sharing stimulus to cover address wrap.
module tb_fifo_to_sram_mc;
  localparam int DW = 32, CW = 5, NC = 4, CB = 2;

  logic              wb_clk = 1'b0;
  logic              wb_rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [CW-1:0]     terminal = '0;
  logic [CW-1:0]     burst_len = '0;
  logic [NC-1:0]     empty = '1;
  logic [NC*CW-1:0]  number_samples = '0;
  logic [NC*DW-1:0]  fifo_data_in = '0;
  logic              grant = 1'b0;
  logic              data_done = 1'b0;

  logic [NC-1:0]     pop_m, pop_w;
  logic              start_m, start_w, busy_m, busy_w;
  logic [DW-1:0]     data_m, data_w;
  logic [CB+8-1:0]   addr_m;
  logic [CB+2-1:0]   addr_w;

  fifo_to_sram_mc #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .NUM_CH(NC), .CH_BITS(CB), .OFS_WIDTH(8)) u_main (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .enable(enable), .terminal(terminal), .burst_len(burst_len),
    .empty(empty), .number_samples(number_samples), .fifo_data_in(fifo_data_in), .grant(grant),
    .data_done(data_done), .pop(pop_m), .sram_start(start_m), .sram_data_out(data_m),
    .sram_addr(addr_m), .busy(busy_m));

  fifo_to_sram_mc #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .NUM_CH(NC), .CH_BITS(CB), .OFS_WIDTH(2)) u_wrap (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .enable(enable), .terminal(terminal), .burst_len(burst_len),
    .empty(empty), .number_samples(number_samples), .fifo_data_in(fifo_data_in), .grant(grant),
    .data_done(data_done), .pop(pop_w), .sram_start(start_w), .sram_data_out(data_w),
    .sram_addr(addr_w), .busy(busy_w));

  always #5 wb_clk = ~wb_clk;

  int n_comp = 0;
  int n_fail = 0;
  int pop_total = 0;

  typedef struct {
    logic [DW-1:0]   d;
    logic [CB+8-1:0] a;
    logic [CB+2-1:0] aw;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_comp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_w(input logic [DW-1:0] d, input int c, input int ofs);
    exp_t e;
    logic [7:0] o8;
    logic [1:0] c2;
    o8 = 8'(ofs);
    c2 = 2'(c);
    e.d  = d;
    e.a  = {c2, o8};
    e.aw = {c2, o8[1:0]};
    sb.push_back(e);
  endtask

  // FIFO model: one push request per negedge, pops sampled on negedge
  logic [DW-1:0] fq [NC][$];
  logic          push_req = 1'b0;
  int            push_ch = 0;
  logic [DW-1:0] push_data = '0;
  logic [NC-1:0] pop_prev = '0;

  always @(negedge wb_clk) begin
    if (!wb_rst_n) begin
      for (int c = 0; c < NC; c++) fq[c].delete();
    end else begin
      if (pop_m != '0) begin
        pop_total++;
        chk("pop_onehot", 64'($countones(pop_m)), 64'd1);
        chk("pop_width", 64'(pop_prev), 64'd0);
        for (int c = 0; c < NC; c++)
          if (pop_m[c]) begin
            chk("pop_while_empty", 64'(fq[c].size() == 0), 64'd0);
            if (fq[c].size() > 0) fifo_data_in[c*DW +: DW] = fq[c].pop_front();
          end
      end
      if (push_req) fq[push_ch].push_back(push_data);
    end
    pop_prev = pop_m;
    for (int c = 0; c < NC; c++) begin
      empty[c] = (fq[c].size() == 0);
      number_samples[c*CW +: CW] = CW'(fq[c].size());
    end
  end

  // SRAM writer model: grant 2..10 cycles after start, data_done 1..3 cycles later
  int wst = 0;
  int wdly = 0;
  always @(negedge wb_clk) begin
    if (!wb_rst_n) begin
      grant = 1'b0; data_done = 1'b0; wst = 0;
    end else begin
      case (wst)
        0: begin
          data_done = 1'b0;
          if (start_m) begin wdly = int'($urandom_range(10, 2)) - 1; wst = 1; end
        end
        1: if (wdly <= 1) begin grant = 1'b1; wst = 2; end else wdly--;
        2: begin grant = 1'b0; wdly = int'($urandom_range(3, 1)); wst = 3; end
        default: if (wdly <= 1) begin data_done = 1'b1; wst = 0; end else wdly--;
      endcase
    end
  end

  // Monitor: every completed word is compared against the next expected write
  always @(negedge wb_clk) begin
    #1;
    if (wb_rst_n && data_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(addr_m), 64'h3ff_ffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_data", 64'(data_m), 64'(e.d));
        chk("wr_addr", 64'(addr_m), 64'(e.a));
        chk("wr_addr_wrap", 64'(addr_w), 64'(e.aw));
      end
    end
  end

  task automatic push(input int c, input logic [DW-1:0] d);
    push_ch = c; push_data = d; push_req = 1'b1;
    @(negedge wb_clk); #1;
    push_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!(sb.size() == 0 && !busy_m) && t < 3000) begin
      @(negedge wb_clk); #2; t++;
    end
    chk({name, "_timeout"}, 64'(t >= 3000), 64'd0);
    repeat (20) @(negedge wb_clk);
    #2;
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge wb_clk); #2;
    wb_rst_n = 1'b0;
    repeat (2) @(negedge wb_clk);
    #2 wb_rst_n = 1'b1;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_pop"},   64'(pop_m),   64'd0);
    chk({name, "_start"}, 64'(start_m), 64'd0);
    chk({name, "_data"},  64'(data_m),  64'd0);
    chk({name, "_addr"},  64'(addr_m),  64'd0);
    chk({name, "_busy"},  64'(busy_m),  64'd0);
  endtask

  initial begin
    int t;
    int pops_before;
    #77 wb_rst_n = 1'b1;
    #1 check_zero("reset");

    // single channel, threshold 4, one word per selection
    terminal = 5'd4; burst_len = 5'd1;
    expect_w(32'ha5b6c7d8, 0, 0);
    expect_w(32'he9fa0123, 0, 1);
    push(0, 32'ha5b6c7d8); push(0, 32'he9fa0123); push(0, 32'h4567890a);
    push(0, 32'h55555555); push(0, 32'haaaaaaaa);
    enable = 1'b1;
    wait_done("single_a");
    expect_w(32'h4567890a, 0, 2);
    expect_w(32'h55555555, 0, 3);
    expect_w(32'haaaaaaaa, 0, 4);
    push(0, 32'h11111111); push(0, 32'h22222222); push(0, 32'h33333333);
    wait_done("single_b");

    // round robin across four channels, burst of 2
    do_reset();
    enable = 1'b0; terminal = 5'd4; burst_len = 5'd2;
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < 2; i++) expect_w(32'h1000_0000 + 32'(c*16 + i), c, i);
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < 4; i++) push(c, 32'h1000_0000 + 32'(c*16 + i));
    enable = 1'b1;
    wait_done("rr_a");
    expect_w(32'h1000_0002, 0, 2);
    expect_w(32'h1000_0003, 0, 3);
    push(0, 32'h1000_0004); push(0, 32'h1000_0005);
    wait_done("rr_b");

    // early stop: burst of 8 on 3 samples
    do_reset();
    enable = 1'b0; terminal = 5'd1; burst_len = 5'd8;
    for (int i = 0; i < 3; i++) begin
      expect_w(32'hbeef_0100 + 32'(i), 1, i);
      push(1, 32'hbeef_0100 + 32'(i));
    end
    enable = 1'b1;
    wait_done("early");

    // offset wrap on the 2-bit instance
    do_reset();
    enable = 1'b0; terminal = 5'd1; burst_len = 5'd8;
    for (int i = 0; i < 6; i++) begin
      expect_w(32'hcafe_0200 + 32'(i), 2, i);
      push(2, 32'hcafe_0200 + 32'(i));
    end
    enable = 1'b1;
    wait_done("wrap");

    // enable dropped mid-burst: burst completes, nothing new starts
    do_reset();
    enable = 1'b0; terminal = 5'd1; burst_len = 5'd4;
    for (int i = 0; i < 4; i++) begin
      expect_w(32'hd00d_0300 + 32'(i), 3, i);
      push(3, 32'hd00d_0300 + 32'(i));
    end
    enable = 1'b1;
    t = 0;
    while (!start_m && t < 100) begin @(negedge wb_clk); #2; t++; end
    chk("en_start_timeout", 64'(t >= 100), 64'd0);
    enable = 1'b0;
    wait_done("en_drop");
    push(3, 32'h7777_0000); push(3, 32'h7777_0001);
    pops_before = pop_total;
    repeat (30) @(negedge wb_clk);
    #2;
    chk("en_no_pop", 64'(pop_total - pops_before), 64'd0);
    chk("en_busy", 64'(busy_m), 64'd0);

    // reset asserted in XFER: outputs clear, popped sample is lost
    enable = 1'b1;
    t = 0;
    while (!grant && t < 100) begin @(negedge wb_clk); #1; t++; end
    chk("xfer_grant_timeout", 64'(t >= 100), 64'd0);
    @(negedge wb_clk); #2;
    chk("xfer_busy_before", 64'(busy_m), 64'd1);
    wb_rst_n = 1'b0;
    #1 check_zero("xfer_rst");
    repeat (2) @(negedge wb_clk);
    #2 wb_rst_n = 1'b1;
    pops_before = pop_total;
    repeat (20) @(negedge wb_clk);
    #2;
    chk("xfer_no_pop", 64'(pop_total - pops_before), 64'd0);
    chk("xfer_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
